// File: rtl/program_sequencer_pkg.sv
// Shared sequencing opcodes and control-state encodings used by the sequencer
// and by the control-unit encoder that produces op.
package program_sequencer_pkg;

    typedef enum logic [2:0] {
        SEQ_NEXT = 3'b000,
        SEQ_JMP  = 3'b001,
        SEQ_JZ   = 3'b010,
        SEQ_JNZ  = 3'b011,
        SEQ_CALL = 3'b100,
        SEQ_RET  = 3'b101,
        SEQ_HALT = 3'b110,
        SEQ_SKPZ = 3'b111
    } seq_op_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } seq_state_e;

endpackage

// File: rtl/program_sequencer_seq_stack.sv
// Return-address LIFO. Push is ignored when full and pop when empty; only the
// occupancy counter is reset, the storage itself is don't-care after reset.
module program_sequencer_seq_stack #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    localparam int DEPTH_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [WIDTH-1:0]   din,
    output logic [WIDTH-1:0]   top,
    output logic [DEPTH_W-1:0] depth,
    output logic               full,
    output logic               empty
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]   mem_q [2**IDX_W];
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic [IDX_W-1:0]   wr_idx, rd_idx;
    logic               do_push, do_pop;

    assign full    = (depth_q == DEPTH_W'(DEPTH));
    assign empty   = (depth_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // depth_q points one past the top entry
    assign wr_idx  = IDX_W'(depth_q);
    assign rd_idx  = IDX_W'(depth_q - DEPTH_W'(1));
    assign top     = mem_q[rd_idx];
    assign depth   = depth_q;

    always_comb begin
        depth_d = depth_q;
        if (do_push) begin
            depth_d = depth_q + DEPTH_W'(1);
        end else if (do_pop) begin
            depth_d = depth_q - DEPTH_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// Program sequencer: registered ROM address, next-address mux, call/return
// stack and RUN/HALT/FAULT control FSM.
module program_sequencer
    import program_sequencer_pkg::*;
#(
    parameter int                ADDR_W      = 4,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
    localparam int               DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [2:0]         op,
    input  logic [ADDR_W-1:0]  target,
    input  logic               zed,
    output logic [ADDR_W-1:0]  addr,
    output logic [DEPTH_W-1:0] depth,
    output logic               stack_full,
    output logic               stack_empty,
    output logic               halted,
    output logic               fault
);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] addr_inc, addr_inc2, stack_top;
    logic              stk_push, stk_pop;

    assign addr_inc  = addr_q + ADDR_W'(1);
    assign addr_inc2 = addr_q + ADDR_W'(2);

    program_sequencer_seq_stack #(
        .WIDTH (ADDR_W),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (addr_inc),
        .top   (stack_top),
        .depth (depth),
        .full  (stack_full),
        .empty (stack_empty)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (en) begin
                    case (op)
                        SEQ_NEXT: addr_d = addr_inc;
                        SEQ_JMP:  addr_d = target;
                        SEQ_JZ:   addr_d = zed ? target : addr_inc;
                        SEQ_JNZ:  addr_d = zed ? addr_inc : target;
                        SEQ_CALL: begin
                            if (stack_full) begin
                                state_d = ST_FAULT;
                            end else begin
                                stk_push = 1'b1;
                                addr_d   = target;
                            end
                        end
                        SEQ_RET: begin
                            if (stack_empty) begin
                                state_d = ST_FAULT;
                            end else begin
                                stk_pop = 1'b1;
                                addr_d  = stack_top;
                            end
                        end
                        SEQ_HALT: state_d = ST_HALT;
                        SEQ_SKPZ: addr_d = zed ? addr_inc2 : addr_inc;
                        default:  addr_d = addr_q;
                    endcase
                end
            end
            // HALT and FAULT are left only through reset
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            addr_q  <= RESET_VEC;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    assign addr   = addr_q;
    assign halted = (state_q == ST_HALT);
    assign fault  = (state_q == ST_FAULT);

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer (ADDR_W=4, STACK_DEPTH=4, RESET_VEC=0).
module tb_program_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [2:0] op;
    logic [3:0] target;
    logic       zed;
    logic [3:0] addr;
    logic [2:0] depth;
    logic       stack_full, stack_empty, halted, fault;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] NEXT = 3'b000, JMP = 3'b001, JZ = 3'b010, JNZ = 3'b011,
                           CALL = 3'b100, RET = 3'b101, HALT = 3'b110, SKPZ = 3'b111;

    program_sequencer #(
        .ADDR_W      (4),
        .STACK_DEPTH (4),
        .RESET_VEC   (4'd0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .op          (op),
        .target      (target),
        .zed         (zed),
        .addr        (addr),
        .depth       (depth),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .halted      (halted),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_ad(input string tag, input int exp_addr, input int exp_depth);
        chk({tag, ".addr"}, int'(addr), exp_addr);
        chk({tag, ".depth"}, int'(depth), exp_depth);
    endtask

    task automatic chk_flags(input string tag, input int full, input int empty,
                             input int hlt, input int flt);
        chk({tag, ".full"}, int'(stack_full), full);
        chk({tag, ".empty"}, int'(stack_empty), empty);
        chk({tag, ".halted"}, int'(halted), hlt);
        chk({tag, ".fault"}, int'(fault), flt);
    endtask

    // Apply one instruction and sample 1 time unit after the rising edge
    task automatic cyc(input logic [2:0] o, input logic [3:0] t, input logic z);
        op = o;
        target = t;
        zed = z;
        @(posedge clk);
        #1;
    endtask

    // Reset pulse between edges; state must clear without waiting for a clock
    task automatic pulse_reset(input string tag);
        op = NEXT;
        rst = 1'b0;
        #1;
        chk_ad(tag, 0, 0);
        chk_flags(tag, 0, 1, 0, 0);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        en = 1'b1;
        op = NEXT;
        target = 4'd0;
        zed = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_ad("reset", 0, 0);
        chk_flags("reset", 0, 1, 0, 0);
        rst = 1'b1;

        for (int i = 0; i < 16; i++) begin
            cyc(NEXT, 4'd0, 1'b0);
            chk("next.addr", int'(addr), (i + 1) % 16);
        end
        chk_flags("next", 0, 1, 0, 0);

        cyc(JMP, 4'd3, 1'b0);  chk("jmp3", int'(addr), 3);
        cyc(JZ, 4'd9, 1'b1);   chk("jz_taken", int'(addr), 9);
        cyc(JMP, 4'd3, 1'b0);  chk("jmp3b", int'(addr), 3);
        cyc(JZ, 4'd9, 1'b0);   chk("jz_fall", int'(addr), 4);
        cyc(JNZ, 4'd9, 1'b0);  chk("jnz_taken", int'(addr), 9);
        cyc(JNZ, 4'd2, 1'b1);  chk("jnz_fall", int'(addr), 10);
        cyc(JMP, 4'd14, 1'b0); chk("jmp14", int'(addr), 14);
        cyc(SKPZ, 4'd7, 1'b1); chk("skpz_wrap", int'(addr), 0);
        cyc(SKPZ, 4'd7, 1'b0); chk("skpz_fall", int'(addr), 1);

        cyc(JMP, 4'd2, 1'b0);  chk_ad("jmp2", 2, 0);
        cyc(CALL, 4'd10, 1'b0); chk_ad("call1", 10, 1);
        chk_flags("call1", 0, 0, 0, 0);
        cyc(JMP, 4'd12, 1'b0); chk_ad("jmp12", 12, 1);
        cyc(CALL, 4'd5, 1'b0); chk_ad("call2", 5, 2);
        cyc(RET, 4'd0, 1'b0);  chk_ad("ret1", 13, 1);
        cyc(RET, 4'd0, 1'b0);  chk_ad("ret2", 3, 0);
        chk_flags("ret2", 0, 1, 0, 0);
        cyc(JMP, 4'd15, 1'b0); chk("jmp15", int'(addr), 15);
        cyc(CALL, 4'd4, 1'b0); chk_ad("call_wrap", 4, 1);
        cyc(RET, 4'd0, 1'b0);  chk_ad("ret_wrap", 0, 0);

        cyc(CALL, 4'd1, 1'b0); chk_ad("fill1", 1, 1);
        cyc(CALL, 4'd2, 1'b0); chk_ad("fill2", 2, 2);
        cyc(CALL, 4'd3, 1'b0); chk_ad("fill3", 3, 3);
        chk_flags("fill3", 0, 0, 0, 0);
        cyc(CALL, 4'd7, 1'b0); chk_ad("fill4", 7, 4);
        chk_flags("fill4", 1, 0, 0, 0);
        cyc(CALL, 4'd9, 1'b0); chk_ad("overflow", 7, 4);
        chk_flags("overflow", 1, 0, 0, 1);
        cyc(RET, 4'd0, 1'b0);  chk_ad("fault_ret", 7, 4);
        cyc(JMP, 4'd0, 1'b0);  chk_ad("fault_jmp", 7, 4);
        chk("fault_sticky", int'(fault), 1);
        pulse_reset("rst_ovf");

        cyc(JMP, 4'd6, 1'b0);  chk_ad("jmp6", 6, 0);
        cyc(RET, 4'd0, 1'b0);  chk_ad("underflow", 6, 0);
        chk_flags("underflow", 0, 1, 0, 1);
        cyc(NEXT, 4'd0, 1'b0); chk("udf_hold", int'(addr), 6);
        pulse_reset("rst_udf");

        cyc(JMP, 4'd5, 1'b0);  chk("jmp5", int'(addr), 5);
        cyc(HALT, 4'd0, 1'b0); chk_ad("halt", 5, 0);
        chk_flags("halt", 0, 1, 1, 0);
        for (int i = 0; i < 10; i++) begin
            cyc((i % 2) ? JMP : CALL, 4'd12, 1'b1);
            chk("halt_hold.addr", int'(addr), 5);
            chk("halt_hold.depth", int'(depth), 0);
            chk("halt_hold.halted", int'(halted), 1);
        end
        pulse_reset("rst_halt");

        en = 1'b0;
        cyc(JMP, 4'd8, 1'b0);  chk_ad("en0_jmp", 0, 0);
        cyc(CALL, 4'd8, 1'b0); chk_ad("en0_call", 0, 0);
        cyc(HALT, 4'd0, 1'b0); chk("en0_halt", int'(halted), 0);
        en = 1'b1;

        cyc(JMP, 4'd9, 1'b0);  chk_ad("jmp9", 9, 0);
        cyc(CALL, 4'd2, 1'b0); chk_ad("call_pre", 2, 1);
        op = CALL;
        target = 4'd11;
        #3;
        rst = 1'b0;
        #1;
        chk_ad("async_rst", 0, 0);
        chk_flags("async_rst", 0, 1, 0, 0);
        @(posedge clk);
        #1;
        chk_ad("async_rst_held", 0, 0);
        rst = 1'b1;
        cyc(NEXT, 4'd0, 1'b0); chk_ad("post_rst", 1, 0);
        cyc(RET, 4'd0, 1'b0);  chk("post_rst_ret", int'(fault), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
